// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Buffers bytes from uart_rx in a small FIFO and turns single-character ASCII
//   commands into one-clock control pulses, echoing each consumed byte back to
//   uart_tx ('?' for unknown bytes, nothing for CR/LF).
// Ports
//   clk, rst            system clock; synchronous active-low reset
//   rx_data, rx_done    received byte and its one-clock strobe
//   tx_busy, tx_done    uart_tx frame in progress / frame finished strobe
//   tx_start, tx_data   one-clock transmit request and the byte (held until tx_done)
//   cmd_run/clear/mode/sr04/dht11   one-clock command pulses
//   overflow            sticky: a byte arrived while the FIFO was full
//   err_cnt             saturating count of unknown bytes
module uart_cmd_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter bit ECHO_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       cmd_run,
  output logic       cmd_clear,
  output logic       cmd_mode,
  output logic       cmd_sr04,
  output logic       cmd_dht11,
  output logic       overflow,
  output logic [7:0] err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ECHO_START, S_ECHO_WAIT} state_t;

  state_t      state, state_n;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;
  logic [7:0]  cmd_reg;
  logic [4:0]  cmd_vec, cmd_n, cmd_pulse;   // [0]run [1]clear [2]mode [3]sr04 [4]dht11
  logic        is_eol, is_known;
  logic [7:0]  echo_byte;
  logic        err_inc, tx_start_n, load_tx;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == S_IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push  = rx_done && (!full || pop);

  always_comb begin
    cmd_vec = '0;
    is_eol  = 1'b0;
    case (cmd_reg)
      8'h52, 8'h72: cmd_vec[0] = 1'b1;
      8'h43, 8'h63: cmd_vec[1] = 1'b1;
      8'h4D, 8'h6D: cmd_vec[2] = 1'b1;
      8'h55, 8'h75: cmd_vec[3] = 1'b1;
      8'h54, 8'h74: cmd_vec[4] = 1'b1;
      8'h0D, 8'h0A: is_eol     = 1'b1;
      default: ;
    endcase
  end

  assign is_known  = |cmd_vec;
  assign echo_byte = is_known ? cmd_reg : 8'h3F;

  always_comb begin
    state_n    = state;
    cmd_n      = '0;
    err_inc    = 1'b0;
    tx_start_n = 1'b0;
    load_tx    = 1'b0;
    case (state)
      S_IDLE:   if (!empty) state_n = S_DECODE;
      S_DECODE: begin
        cmd_n = cmd_vec;
        if (is_eol) begin
          state_n = S_IDLE;
        end else begin
          err_inc = !is_known;
          load_tx = ECHO_EN;
          state_n = ECHO_EN ? S_ECHO_START : S_IDLE;
        end
      end
      S_ECHO_START: if (!tx_busy) begin
        tx_start_n = 1'b1;
        state_n    = S_ECHO_WAIT;
      end
      // tx_busy may lag tx_start by a clock, so only tx_done ends the wait.
      S_ECHO_WAIT: if (tx_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Storage needs no reset; emptiness is carried by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_reg   <= '0;
      cmd_pulse <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      overflow  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      cmd_pulse <= cmd_n;
      tx_start  <= tx_start_n;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (rx_done && !push) overflow <= 1'b1;
      if (pop) begin
        cmd_reg <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (load_tx) tx_data <= echo_byte;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign cmd_run   = cmd_pulse[0];
  assign cmd_clear = cmd_pulse[1];
  assign cmd_mode  = cmd_pulse[2];
  assign cmd_sr04  = cmd_pulse[3];
  assign cmd_dht11 = cmd_pulse[4];

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: random and directed byte streams against a
// queue-based reference of expected command pulses, echo bytes and error count.
module tb_uart_cmd_decoder;
  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       tx_busy, tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       cmd_run, cmd_clear, cmd_mode, cmd_sr04, cmd_dht11, overflow;
  logic [7:0] err_cnt;

  logic tx_hold = 1'b0, resp_busy = 1'b0, tx_auto = 1'b1;
  assign tx_busy = tx_hold | resp_busy;

  uart_cmd_decoder #(.FIFO_DEPTH(4), .ECHO_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .cmd_run(cmd_run), .cmd_clear(cmd_clear), .cmd_mode(cmd_mode),
    .cmd_sr04(cmd_sr04), .cmd_dht11(cmd_dht11), .overflow(overflow), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  localparam int TX_LAT = 3;
  int n_chk = 0, n_pass = 0;
  int multi_hot = 0, unstable = 0, exp_err = 0;
  int cmd_q[$], exp_cmd[$];
  logic [7:0] echo_q[$], exp_echo[$];
  logic [7:0] resp_d;
  logic [7:0] letters [5] = '{8'h52, 8'h43, 8'h4D, 8'h55, 8'h54};

  // Observed pulses/echoes, one entry per high cycle.
  always @(negedge clk) if (rst) begin
    if ($countones({cmd_run, cmd_clear, cmd_mode, cmd_sr04, cmd_dht11}) > 1) multi_hot++;
    if (cmd_run)   cmd_q.push_back(0);
    if (cmd_clear) cmd_q.push_back(1);
    if (cmd_mode)  cmd_q.push_back(2);
    if (cmd_sr04)  cmd_q.push_back(3);
    if (cmd_dht11) cmd_q.push_back(4);
    if (tx_start)  echo_q.push_back(tx_data);
  end

  // uart_tx stand-in: busy a few clocks after tx_start, then a tx_done strobe.
  initial forever begin
    @(negedge clk);
    if (tx_auto && tx_start) begin
      resp_d = tx_data;
      resp_busy = 1'b1;
      repeat (TX_LAT) begin
        @(negedge clk);
        if (tx_data !== resp_d) unstable++;
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      resp_busy = 1'b0;
    end
  end

  // Reference: what a byte should produce, from the command table alone.
  task automatic model_byte(input logic [7:0] b);
    int c;
    case (b)
      8'h52, 8'h72: c = 0;
      8'h43, 8'h63: c = 1;
      8'h4D, 8'h6D: c = 2;
      8'h55, 8'h75: c = 3;
      8'h54, 8'h74: c = 4;
      8'h0D, 8'h0A: c = 5;
      default:      c = 6;
    endcase
    if (c < 5) begin exp_cmd.push_back(c); exp_echo.push_back(b); end
    else if (c == 6) begin
      exp_echo.push_back(8'h3F);
      if (exp_err < 255) exp_err++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge one half-cycle after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; idle(3);
    n_chk++;
    if ({tx_start, tx_data, cmd_run, cmd_clear, cmd_mode, cmd_sr04, cmd_dht11, overflow, err_cnt} !== 23'd0)
      $display("FAIL reset_outputs got %h want 0", {tx_start, tx_data, cmd_run, cmd_clear, cmd_mode, cmd_sr04, cmd_dht11, overflow, err_cnt});
    else n_pass++;
    rst = 1'b1; idle(2);
  endtask

  task automatic test_run_latency;
    int bc, be;
    bc = cmd_q.size(); be = echo_q.size(); exp_cmd.delete(); exp_echo.delete();
    model_byte(8'h52);
    send_byte(8'h52);
    n_chk++; if (cmd_run !== 1'b0) $display("FAIL lat_c0 cmd_run=%b want 0", cmd_run); else n_pass++;
    idle(1);
    n_chk++; if (cmd_run !== 1'b0) $display("FAIL lat_c1 cmd_run=%b want 0", cmd_run); else n_pass++;
    idle(1);
    n_chk++; if (cmd_run !== 1'b1) $display("FAIL lat_c2 cmd_run=%b want 1", cmd_run); else n_pass++;
    idle(1);
    n_chk++; if (cmd_run !== 1'b0) $display("FAIL lat_c3 cmd_run=%b want 0", cmd_run); else n_pass++;
    idle(20);
    n_chk++;
    if (cmd_q.size() - bc != exp_cmd.size() || echo_q.size() - be != exp_echo.size())
      $display("FAIL run_counts cmds=%0d echoes=%0d want %0d/%0d", cmd_q.size() - bc, echo_q.size() - be, exp_cmd.size(), exp_echo.size());
    else n_pass++;
    n_chk++;
    if (echo_q.size() > be && echo_q[be] !== exp_echo[0]) $display("FAIL run_echo got %h want %h", echo_q[be], exp_echo[0]);
    else n_pass++;
  endtask

  task automatic test_clear_unknown;
    int bc, be;
    bc = cmd_q.size(); be = echo_q.size(); exp_cmd.delete(); exp_echo.delete();
    foreach (letters[i]) if (i == 0) begin
      model_byte(8'h63); send_byte(8'h63); idle(15);
      model_byte(8'h78); send_byte(8'h78); idle(15);
      n_chk++; if (err_cnt !== 8'd1) $display("FAIL unk_err got %0d want 1", err_cnt); else n_pass++;
      model_byte(8'h0D); send_byte(8'h0D); idle(15);
    end
    n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL cr_err got %0d want %0d", err_cnt, exp_err); else n_pass++;
    n_chk++;
    if (cmd_q.size() - bc != exp_cmd.size() || echo_q.size() - be != exp_echo.size())
      $display("FAIL cu_counts cmds=%0d echoes=%0d want %0d/%0d", cmd_q.size() - bc, echo_q.size() - be, exp_cmd.size(), exp_echo.size());
    else n_pass++;
    for (int i = 0; i < exp_cmd.size() && bc + i < cmd_q.size(); i++) begin
      n_chk++; if (cmd_q[bc+i] != exp_cmd[i]) $display("FAIL cu_cmd%0d got %0d want %0d", i, cmd_q[bc+i], exp_cmd[i]); else n_pass++;
    end
    for (int i = 0; i < exp_echo.size() && be + i < echo_q.size(); i++) begin
      n_chk++; if (echo_q[be+i] !== exp_echo[i]) $display("FAIL cu_echo%0d got %h want %h", i, echo_q[be+i], exp_echo[i]); else n_pass++;
    end
  endtask

  task automatic test_overflow;
    int bc, be;
    logic [7:0] seq [6] = '{8'h52, 8'h43, 8'h4D, 8'h55, 8'h54, 8'h52};
    bc = cmd_q.size(); be = echo_q.size(); exp_cmd.delete(); exp_echo.delete();
    tx_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); rx_data = seq[i]; rx_done = 1'b1;
      if (i < 5) model_byte(seq[i]);
    end
    @(negedge clk); rx_done = 1'b0;
    idle(5);
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
    n_chk++; if (echo_q.size() != be) $display("FAIL ovf_hold echoes=%0d want 0", echo_q.size() - be); else n_pass++;
    tx_hold = 1'b0;
    idle(80);
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
    n_chk++;
    if (cmd_q.size() - bc != exp_cmd.size() || echo_q.size() - be != exp_echo.size())
      $display("FAIL ovf_counts cmds=%0d echoes=%0d want %0d/%0d", cmd_q.size() - bc, echo_q.size() - be, exp_cmd.size(), exp_echo.size());
    else n_pass++;
    for (int i = 0; i < exp_echo.size() && be + i < echo_q.size(); i++) begin
      n_chk++; if (echo_q[be+i] !== exp_echo[i]) $display("FAIL ovf_echo%0d got %h want %h", i, echo_q[be+i], exp_echo[i]); else n_pass++;
    end
    for (int i = 0; i < exp_cmd.size() && bc + i < cmd_q.size(); i++) begin
      n_chk++; if (cmd_q[bc+i] != exp_cmd[i]) $display("FAIL ovf_cmd%0d got %0d want %0d", i, cmd_q[bc+i], exp_cmd[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int be, bc2, be2;
    be = echo_q.size();
    tx_auto = 1'b0;
    send_byte(8'h52); idle(10);
    send_byte(8'h43); idle(2);
    send_byte(8'h4D); idle(3);
    n_chk++; if (echo_q.size() - be != 1) $display("FAIL mid_wait echoes=%0d want 1", echo_q.size() - be); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    exp_err = 0;
    n_chk++;
    if ({tx_start, tx_data, cmd_run, cmd_clear, cmd_mode, cmd_sr04, cmd_dht11, overflow, err_cnt} !== 23'd0)
      $display("FAIL mid_reset_outputs got %h want 0", {tx_start, tx_data, cmd_run, cmd_clear, cmd_mode, cmd_sr04, cmd_dht11, overflow, err_cnt});
    else n_pass++;
    bc2 = cmd_q.size(); be2 = echo_q.size();
    idle(20);
    n_chk++;
    if (cmd_q.size() != bc2 || echo_q.size() != be2)
      $display("FAIL mid_quiet cmds=%0d echoes=%0d want 0/0", cmd_q.size() - bc2, echo_q.size() - be2);
    else n_pass++;
    tx_auto = 1'b1;
    send_byte(8'h6D); idle(20);
    n_chk++;
    if (cmd_q.size() - bc2 != 1 || echo_q.size() - be2 != 1 || cmd_q[bc2] != 2 || echo_q[be2] !== 8'h6D)
      $display("FAIL mid_fifo_empty cmds=%0d echoes=%0d want one mode pulse and echo 6d", cmd_q.size() - bc2, echo_q.size() - be2);
    else n_pass++;
  endtask

  task automatic rand_byte(output logic [7:0] b);
    int k;
    k = $urandom_range(0, 9);
    if (k <= 5) b = letters[$urandom_range(0, 4)] | ($urandom_range(0, 1) ? 8'h20 : 8'h00);
    else if (k == 6) b = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
    else b = 8'($urandom_range(0, 255));
  endtask

  task automatic test_random(input int n, input bit burst);
    int bc, be;
    logic [7:0] b;
    bc = cmd_q.size(); be = echo_q.size(); exp_cmd.delete(); exp_echo.delete();
    for (int i = 0; i < n; i++) begin
      rand_byte(b);
      model_byte(b);
      if (burst) begin
        @(negedge clk); rx_data = b; rx_done = 1'b1;
      end else begin
        send_byte(b); idle($urandom_range(7, 15));
      end
    end
    @(negedge clk); rx_done = 1'b0;
    idle(80);
    n_chk++;
    if (cmd_q.size() - bc != exp_cmd.size() || echo_q.size() - be != exp_echo.size())
      $display("FAIL rnd%0d_counts cmds=%0d echoes=%0d want %0d/%0d", burst, cmd_q.size() - bc, echo_q.size() - be, exp_cmd.size(), exp_echo.size());
    else n_pass++;
    for (int i = 0; i < exp_cmd.size() && bc + i < cmd_q.size(); i++) begin
      n_chk++; if (cmd_q[bc+i] != exp_cmd[i]) $display("FAIL rnd%0d_cmd%0d got %0d want %0d", burst, i, cmd_q[bc+i], exp_cmd[i]); else n_pass++;
    end
    for (int i = 0; i < exp_echo.size() && be + i < echo_q.size(); i++) begin
      n_chk++; if (echo_q[be+i] !== exp_echo[i]) $display("FAIL rnd%0d_echo%0d got %h want %h", burst, i, echo_q[be+i], exp_echo[i]); else n_pass++;
    end
    n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL rnd%0d_err got %0d want %0d", burst, err_cnt, exp_err); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL rnd%0d_ovf got %b want 0", burst, overflow); else n_pass++;
  endtask

  task automatic test_saturate;
    int bc, be;
    bc = cmd_q.size(); be = echo_q.size();
    for (int i = 0; i < 260; i++) begin
      model_byte(8'h21);
      send_byte(8'h21); idle(7);
    end
    idle(30);
    n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL sat_err got %0d want %0d", err_cnt, exp_err); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL sat_ovf got %b want 0", overflow); else n_pass++;
    n_chk++;
    if (cmd_q.size() != bc || echo_q.size() - be != 260)
      $display("FAIL sat_counts cmds=%0d echoes=%0d want 0/260", cmd_q.size() - bc, echo_q.size() - be);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_run_latency();
    test_clear_unknown();
    test_overflow();
    test_reset_mid();
    test_random(30, 1'b0);
    test_random(5, 1'b1);
    test_saturate();
    n_chk++; if (multi_hot != 0) $display("FAIL one_hot cycles_with_multiple=%0d want 0", multi_hot); else n_pass++;
    n_chk++; if (unstable != 0) $display("FAIL tx_data_stable changes=%0d want 0", unstable); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
